// File: rtl/serial_tx_pkg.sv
// Shared definitions for the serial link: FSM state encoding and default
// frame constants used by both the transmitter and the receiver.
package serial_tx_pkg;

  // 3-bit state encoding, kept as plain constants so older tools can use it
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  // Default frame shape: 8 data bits, even parity, 16 clocks per bit
  localparam int DEF_DATA_W       = 8;
  localparam int DEF_CLKS_PER_BIT = 16;
  localparam int DEF_PARITY_EN    = 1;
  localparam int DEF_PARITY_ODD   = 0;

endpackage

// File: rtl/serial_tx_baud_gen.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 while enabled and flags the
// last cycle of every bit period. Held at zero while disabled so each frame
// starts on a clean bit boundary.
module serial_tx_baud_gen #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic tick
);

  localparam int            CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign tick = en && (cnt_q == LAST);

  // Next count: wrap on the bit boundary, clear whenever disabled
  always_comb begin
    cnt_d = '0;
    if (en && !tick) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Counter register, cleared asynchronously by reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/serial_tx.sv
// UART-style serial transmitter. A word accepted on the valid/ready
// handshake is framed as start, DATA_W data bits (LSB first), optional
// parity and stop, each bit held for CLKS_PER_BIT clocks. txd is registered
// from the current state, so the line lags the FSM by one clock: the start
// bit appears one edge after the accept edge, and the stop bit naturally
// runs into the single idle cycle that separates back-to-back frames.
module serial_tx
  import serial_tx_pkg::*;
#(
  parameter int DATA_W       = DEF_DATA_W,
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int PARITY_EN    = DEF_PARITY_EN,
  parameter int PARITY_ODD   = DEF_PARITY_ODD
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tx_valid,
  input  logic [DATA_W-1:0] tx_data,
  output logic              tx_ready,
  output logic              txd,
  output logic              busy,
  output logic              done
);

  localparam int            BW         = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [BW-1:0] LAST_BIT   = BW'(DATA_W - 1);
  localparam logic          PAR_SEED   = (PARITY_ODD != 0);
  localparam logic [2:0]    AFTER_DATA = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;

  logic [2:0]        state_q,    state_d;
  logic [BW-1:0]     bit_cnt_q,  bit_cnt_d;
  logic [DATA_W-1:0] shift_q,    shift_d;
  logic              parity_q,   parity_d;
  logic              tx_ready_q, tx_ready_d;
  logic              txd_q,      txd_d;
  logic              done_q,     done_d;
  logic              baud_en;
  logic              tick;

  assign baud_en = (state_q != ST_IDLE);

  serial_tx_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_gen (
    .clk  (clk),
    .reset(reset),
    .en   (baud_en),
    .tick (tick)
  );

  // FSM next state, shift register, bit counter and handshake control
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    parity_d   = parity_q;
    tx_ready_d = tx_ready_q;
    done_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (tx_valid && tx_ready_q) begin
          state_d    = ST_START;
          tx_ready_d = 1'b0;
          shift_d    = tx_data;
          // Parity is fixed at capture time, so later tx_data changes cannot leak in
          parity_d   = (^tx_data) ^ PAR_SEED;
          bit_cnt_d  = '0;
        end
      end
      ST_START: begin
        if (tick) begin
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (tick) begin
          shift_d = shift_q >> 1;
          if (bit_cnt_q == LAST_BIT) begin
            bit_cnt_d = '0;
            state_d   = AFTER_DATA;
          end else begin
            bit_cnt_d = bit_cnt_q + BW'(1);
          end
        end
      end
      ST_PARITY: begin
        if (tick) begin
          state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (tick) begin
          state_d    = ST_IDLE;
          tx_ready_d = 1'b1;
          done_d     = 1'b1;
        end
      end
      default: begin
        state_d    = ST_IDLE;
        tx_ready_d = 1'b1;
      end
    endcase
  end

  // Line level for the bit currently being sent
  always_comb begin
    txd_d = 1'b1;
    case (state_q)
      ST_START:  txd_d = 1'b0;
      ST_DATA:   txd_d = shift_q[0];
      ST_PARITY: txd_d = parity_q;
      default:   txd_d = 1'b1;
    endcase
  end

  // State and datapath registers; reset aborts any frame and idles the line
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      parity_q   <= 1'b0;
      tx_ready_q <= 1'b1;
      txd_q      <= 1'b1;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      parity_q   <= parity_d;
      tx_ready_q <= tx_ready_d;
      txd_q      <= txd_d;
      done_q     <= done_d;
    end
  end

  assign tx_ready = tx_ready_q;
  assign busy     = ~tx_ready_q;
  assign txd      = txd_q;
  assign done     = done_q;

endmodule
